led_color_mixxer: RTL and testbench
===================================

LED_COLOR_MIXXER -- requirements
Module: led_color_mixxer

Interface
- REQ-001 Parameter N, default 8: width of contador, mid_idx and max_idx; legal range 2..16.
- REQ-002 The block SHALL have one clock and an asynchronous, active-high reset, with ports exactly as below.
- REQ-003 clock  input  1  rising-edge system clock.
- REQ-004 reset  input  1  asynchronous active-high reset.
- REQ-005 contador  input  N  unsigned level/position value to colour.
- REQ-006 mid_idx  input  N  unsigned index mapped to pure yellow.
- REQ-007 max_idx  input  N  unsigned index at and above which the colour is pure red.
- REQ-008 cor_led  output  24  registered 8-bit-per-channel colour, default order {R[23:16], G[15:8], B[7:0]}.

Function
- REQ-009 The block SHALL sample contador, mid_idx and max_idx on each rising clock edge and present the matching colour on cor_led after exactly 1 cycle of latency.
- REQ-010 It has no handshake and no state machine: it computes a new colour every cycle, and mid_idx/max_idx may change on any cycle without a restart.
- REQ-011 Blue SHALL always be 8'h00.
- REQ-012 Priority 1: if contador >= max_idx, the output SHALL be R=255, G=0 (red), including when max_idx <= mid_idx.
- REQ-013 Priority 2: else if contador < mid_idx, the output SHALL be R = floor(contador*255/mid_idx), G=255 (green-to-yellow ramp).
- REQ-014 Priority 3: else (mid_idx <= contador < max_idx), the output SHALL be R=255, G = 255 - floor((contador-mid_idx)*255/(max_idx-mid_idx)) (yellow-to-red ramp).
- REQ-015 The priority order above guarantees no divide-by-zero: ramp 2 is used only when mid_idx > 0, and ramp 3 only when max_idx > mid_idx.
- REQ-016 Intermediate products SHALL be N+8 bits wide with no truncation before the division; quotients are at most 255 by construction.
- REQ-017 With mid_idx = 0 the green ramp SHALL be skipped: contador < max_idx uses the yellow-to-red ramp, and otherwise the output is red.
- REQ-018 With max_idx = 0 the output SHALL be red for every contador value.
- REQ-019 The computation SHALL be combinational with a single output register; no multicycle paths.

Reset
- REQ-020 While reset is high, cor_led SHALL be 24'h000000 (black), asynchronously.
- REQ-021 The first valid colour SHALL appear 1 cycle after the first rising edge following reset deassertion.
- REQ-022 Asserting reset mid-operation SHALL force black immediately, with no memory of the prior colour.

Configuration
- REQ-023 The macro LED_COLOR_MIXXER_GRB_EN selects the output byte order.
- REQ-024 With LED_COLOR_MIXXER_GRB_EN defined, cor_led SHALL be {G,R,B} (WS2812 order).
- REQ-025 Without LED_COLOR_MIXXER_GRB_EN, cor_led SHALL be {R,G,B}.
- REQ-026 The reset value SHALL be black in both configurations.

Structure
- REQ-027 Shared package led_color_pkg SHALL hold: colour constants (BLACK 24'h000000, GREEN 24'h00FF00, YELLOW 24'hFFFF00, RED 24'hFF0000), the channel full-scale constant 8'hFF, and the byte-packing function.
- REQ-028 One sub-module, led_ramp_scale, SHALL compute floor(num*255/den) for a parameterised width N.
- REQ-029 led_ramp_scale SHALL be instantiated twice, once per ramp.

Verification (N=8, RGB order unless stated; every check 1 cycle after the input is applied)
- REQ-030 mid=128, max=200; contador = 0, 64, 128 -> cor_led = 00FF00, 7FFF00, FFFF00.
- REQ-031 mid=128, max=200; contador = 164, 200, 255 -> FF8000, FF0000, FF0000.
- REQ-032 Switch on the fly to mid=64, max=180; contador = 32 -> 7FFF00; contador = 122 -> FF8000; no glitch beyond the 1-cycle latency.
- REQ-033 Degenerate: mid=0, max=0 with contador=0 -> FF0000; mid=100, max=50 with contador=75 -> FF0000.
- REQ-034 Assert reset while the output is FF0000 -> 000000 immediately, without waiting for a clock edge; release -> correct colour 1 cycle after the next rising edge.
- REQ-035 Sweep contador 0..200..0 with mid=128, max=200; R SHALL be monotonic non-decreasing and G monotonic non-increasing on the way up, mirrored on the way down.
- REQ-036 Build with LED_COLOR_MIXXER_GRB_EN defined; mid=128, max=200, contador=64 -> FF7F00.

Source files
------------

// File: rtl/led_color_pkg.sv
// led_color_pkg: colour constants and byte packing shared by the LED colour mixer.
// Byte order is selected by LED_COLOR_MIXXER_GRB_EN ({G,R,B} when defined, {R,G,B} otherwise).
package led_color_pkg;

    localparam logic [23:0] BLACK      = 24'h000000;
    localparam logic [23:0] GREEN      = 24'h00FF00;
    localparam logic [23:0] YELLOW     = 24'hFFFF00;
    localparam logic [23:0] RED        = 24'hFF0000;
    localparam logic [7:0]  FULL_SCALE = 8'hFF;

    // Places the three channels in the output byte order of this build.
    function automatic logic [23:0] pack_color(
        input logic [7:0] r,
        input logic [7:0] g,
        input logic [7:0] b
    );
`ifdef LED_COLOR_MIXXER_GRB_EN
        return {g, r, b};
`else
        return {r, g, b};
`endif
    endfunction

endpackage

// File: rtl/led_ramp_scale.sv
// led_ramp_scale: combinational floor(num*255/den) for an N-bit ramp position.
module led_ramp_scale
    import led_color_pkg::*;
#(
    parameter int N = 8
) (
    input  logic [N-1:0] i_num,
    input  logic [N-1:0] i_den,
    output logic [7:0]   o_q
);

    logic [N+7:0] w_prod;
    logic [N+7:0] w_quot;

    // num*255 as (num<<8)-num keeps the full N+8-bit product before dividing.
    assign w_prod = {i_num, 8'h00} - {8'h00, i_num};

    // A zero denominator only occurs when the caller has selected another branch.
    assign w_quot = (i_den == '0) ? '0 : w_prod / {8'h00, i_den};

    // Callers keep num < den so the quotient fits a channel; saturate just in case.
    assign o_q = (|w_quot[N+7:8]) ? FULL_SCALE : w_quot[7:0];

endmodule

// File: rtl/led_color_mixxer.sv
// led_color_mixxer: maps a position to a green->yellow->red colour, registered once.
// Output byte order: {G,R,B} with LED_COLOR_MIXXER_GRB_EN defined, {R,G,B} otherwise.
module led_color_mixxer
    import led_color_pkg::*;
#(
    parameter int N = 8
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [N-1:0] contador,
    input  logic [N-1:0] mid_idx,
    input  logic [N-1:0] max_idx,
    output logic [23:0]  cor_led
);

    logic [N-1:0] w_up_num;
    logic [N-1:0] w_up_den;
    logic [7:0]   w_green_rise;
    logic [7:0]   w_green_drop;
    logic         w_is_red;
    logic         w_is_green_ramp;
    logic [23:0]  w_rgb;
    logic [23:0]  r_cor;

    // Position and span within the yellow-to-red segment.
    assign w_up_num = contador - mid_idx;
    assign w_up_den = max_idx - mid_idx;

    // Red channel rising from 0 to full scale below the yellow point.
    led_ramp_scale #(.N(N)) u_green_ramp (
        .i_num (contador),
        .i_den (mid_idx),
        .o_q   (w_green_rise)
    );

    // Amount removed from green between the yellow point and full red.
    led_ramp_scale #(.N(N)) u_red_ramp (
        .i_num (w_up_num),
        .i_den (w_up_den),
        .o_q   (w_green_drop)
    );

    // Red wins first, so the ramps only see non-zero denominators when selected.
    assign w_is_red        = contador >= max_idx;
    assign w_is_green_ramp = contador < mid_idx;
    assign w_rgb = w_is_red        ? RED :
                   w_is_green_ramp ? (GREEN | {w_green_rise, 16'h0000}) :
                                     (YELLOW - {8'h00, w_green_drop, 8'h00});

    // Single output register; reset forces black without needing a clock edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            r_cor <= BLACK;
        else
            r_cor <= pack_color(w_rgb[23:16], w_rgb[15:8], w_rgb[7:0]);
    end

    assign cor_led = r_cor;

endmodule

// File: tb/tb_led_color_mixxer.sv
// tb_led_color_mixxer: scoreboard bench for led_color_mixxer (honours LED_COLOR_MIXXER_GRB_EN).
module tb_led_color_mixxer;

    typedef struct {
        logic [23:0] exp;
        int          mode;
        string       name;
    } item_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  contador = '0;
    logic [7:0]  mid_idx = '0;
    logic [7:0]  max_idx = '0;
    logic [23:0] cor_led;

    item_t       sb[$];
    item_t       cur;
    int          checks = 0;
    int          errors = 0;
    logic [7:0]  prev_r, prev_g;
    logic        prev_ok = 1'b0;

    led_color_mixxer #(.N(8)) dut (
        .clock    (clock),
        .reset    (reset),
        .contador (contador),
        .mid_idx  (mid_idx),
        .max_idx  (max_idx),
        .cor_led  (cor_led)
    );

    always #5 clock = ~clock;

    function automatic logic [23:0] to_ord(input logic [23:0] rgb);
`ifdef LED_COLOR_MIXXER_GRB_EN
        return {rgb[15:8], rgb[23:16], rgb[7:0]};
`else
        return rgb;
`endif
    endfunction

    function automatic logic [7:0] get_r(input logic [23:0] col);
`ifdef LED_COLOR_MIXXER_GRB_EN
        return col[15:8];
`else
        return col[23:16];
`endif
    endfunction

    function automatic logic [7:0] get_g(input logic [23:0] col);
`ifdef LED_COLOR_MIXXER_GRB_EN
        return col[23:16];
`else
        return col[15:8];
`endif
    endfunction

    function automatic logic [23:0] model(input int c, input int m, input int x);
        int q;
        if (c >= x) return 24'hFF0000;
        if (c < m) begin
            q = (c * 255) / m;
            return {q[7:0], 8'hFF, 8'h00};
        end
        q = 255 - ((c - m) * 255) / (x - m);
        return {8'hFF, q[7:0], 8'h00};
    endfunction

    task automatic check(input string name, input logic [23:0] act, input logic [23:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %06h, expected %06h", name, act, exp);
        end
    endtask

    task automatic apply(input int c, input int m, input int x, input logic [23:0] rgb,
                         input string name, input int mode);
        item_t it;
        @(negedge clock);
        contador = c[7:0];
        mid_idx  = m[7:0];
        max_idx  = x[7:0];
        it.exp  = to_ord(rgb);
        it.mode = mode;
        it.name = name;
        sb.push_back(it);
    endtask

    task automatic drain();
        int i = 0;
        while (sb.size() > 0 && i < 20) begin
            @(negedge clock);
            i++;
        end
        checks++;
        if (sb.size() > 0) begin
            errors++;
            $display("FAIL drain_timeout: %0d pending, expected 0", sb.size());
        end
    endtask

    always @(posedge clock) begin
        #1;
        if (!reset && sb.size() > 0) begin
            cur = sb.pop_front();
            check(cur.name, cor_led, cur.exp);
            if (cur.mode == 1 && prev_ok) begin
                checks++;
                if (get_r(cor_led) < prev_r || get_g(cor_led) > prev_g) begin
                    errors++;
                    $display("FAIL mono_up: r=%02h g=%02h after r=%02h g=%02h",
                             get_r(cor_led), get_g(cor_led), prev_r, prev_g);
                end
            end
            if (cur.mode == 2 && prev_ok) begin
                checks++;
                if (get_r(cor_led) > prev_r || get_g(cor_led) < prev_g) begin
                    errors++;
                    $display("FAIL mono_down: r=%02h g=%02h after r=%02h g=%02h",
                             get_r(cor_led), get_g(cor_led), prev_r, prev_g);
                end
            end
            prev_ok = (cur.mode != 0);
            prev_r  = get_r(cor_led);
            prev_g  = get_g(cor_led);
        end
    end

    initial begin
        #3;
        check("reset_async_start", cor_led, 24'h000000);
        repeat (2) @(posedge clock);
        #1;
        check("reset_held", cor_led, 24'h000000);
        @(negedge clock);
        reset = 1'b0;
        apply(0,   128, 200, 24'h00FF00, "ramp_g_0", 0);
        apply(64,  128, 200, 24'h7FFF00, "ramp_g_64", 0);
        apply(127, 128, 200, 24'hFDFF00, "ramp_g_127", 0);
        apply(128, 128, 200, 24'hFFFF00, "yellow_128", 0);
        apply(164, 128, 200, 24'hFF8000, "ramp_r_164", 0);
        apply(199, 128, 200, 24'hFF0400, "ramp_r_199", 0);
        apply(200, 128, 200, 24'hFF0000, "red_200", 0);
        apply(255, 128, 200, 24'hFF0000, "red_255", 0);
        apply(32,  64,  180, 24'h7FFF00, "fly_32", 0);
        apply(122, 64,  180, 24'hFF8000, "fly_122", 0);
        apply(0,   0,   0,   24'hFF0000, "deg_zero", 0);
        apply(75,  100, 50,  24'hFF0000, "deg_max_lt_mid", 0);
        apply(50,  0,   100, 24'hFF8000, "mid0_ramp", 0);
        apply(5,   3,   0,   24'hFF0000, "max0_red", 0);
        apply(64,  128, 200, 24'h7FFF00, "order_64", 0);
        apply(255, 128, 200, 24'hFF0000, "pre_reset_red", 0);
        drain();
        @(negedge clock);
        #2;
        reset = 1'b1;
        #1;
        check("reset_async_mid", cor_led, 24'h000000);
        @(posedge clock);
        #1;
        check("reset_mid_clocked", cor_led, 24'h000000);
        @(negedge clock);
        reset = 1'b0;
        apply(64,  128, 200, 24'h7FFF00, "post_reset", 0);
        for (int c = 0; c <= 200; c++)
            apply(c, 128, 200, model(c, 128, 200), "sweep_up", 1);
        for (int c = 199; c >= 0; c--)
            apply(c, 128, 200, model(c, 128, 200), "sweep_down", 2);
        drain();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
